// File: rtl/armleocpu_tlb_ctrl_pkg.sv
// Shared widths and controller state encoding for the TLB sequencer.
package armleocpu_tlb_ctrl_pkg;

    localparam int unsigned VPN_W = 20;
    localparam int unsigned PPN_W = 22;
    localparam int unsigned TAG_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StLookup,
        StWalk,
        StFlush
    } tlb_ctrl_state_e;

endpackage

// File: rtl/armleocpu_rr_arbiter2.sv
// Two-way round-robin arbiter: the priority pointer passes to the other requester on each update.
module armleocpu_rr_arbiter2 #(
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic prio_q, prio_d;

    always_comb begin
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        prio_d = prio_q;
        if (update && (gnt != 2'b00)) begin
            prio_d = ~gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= RESET_PRIO[0];
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/armleocpu_tlb_ctrl.sv
// Shares the single-ported TLB between fetch (r0) and load/store (r1): lookup, walk-and-fill,
// and sfence invalidation, one transaction at a time.
module armleocpu_tlb_ctrl
    import armleocpu_tlb_ctrl_pkg::*;
#(
    parameter int unsigned ARB_RESET_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             satp_mode,
    input  logic             flush_req,
    output logic             flush_done,
    input  logic             r0_req,
    input  logic [VPN_W-1:0] r0_vpn,
    output logic             r0_ack,
    input  logic             r1_req,
    input  logic [VPN_W-1:0] r1_vpn,
    output logic             r1_ack,
    output logic [PPN_W-1:0] r_phys,
    output logic [TAG_W-1:0] r_accesstag,
    output logic             r_pagefault,
    output logic             tlb_enable,
    output logic             tlb_resolve,
    output logic             tlb_invalidate,
    output logic             tlb_write,
    output logic [VPN_W-1:0] tlb_vaddr,
    output logic [VPN_W-1:0] tlb_vaddr_w,
    output logic [PPN_W-1:0] tlb_phys_w,
    output logic [TAG_W-1:0] tlb_accesstag_w,
    input  logic             tlb_done,
    input  logic             tlb_miss,
    input  logic [PPN_W-1:0] tlb_phys_r,
    input  logic [TAG_W-1:0] tlb_accesstag_r,
    output logic             ptw_req,
    output logic [VPN_W-1:0] ptw_vpn,
    input  logic             ptw_done,
    input  logic             ptw_fault,
    input  logic [PPN_W-1:0] ptw_phys,
    input  logic [TAG_W-1:0] ptw_accesstag
);

    tlb_ctrl_state_e  state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic             idx_q, idx_d;
    logic             r0_ack_q, r0_ack_d;
    logic             r1_ack_q, r1_ack_d;
    logic             flush_done_q, flush_done_d;
    logic [PPN_W-1:0] phys_q, phys_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             fault_q, fault_d;

    logic [1:0]       req_v;
    logic             flush_v;
    logic [1:0]       gnt;
    logic             arb_update;
    logic [VPN_W-1:0] vpn_sel;

    // A requester still seeing its ack pulse has not yet dropped req; do not serve it twice.
    assign req_v   = {r1_req & ~r1_ack_q, r0_req & ~r0_ack_q};
    assign flush_v = flush_req & ~flush_done_q;
    assign vpn_sel = gnt[1] ? r1_vpn : r0_vpn;

    armleocpu_rr_arbiter2 #(
        .RESET_PRIO (ARB_RESET_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_v),
        .update (arb_update),
        .gnt    (gnt)
    );

    always_comb begin
        state_d      = state_q;
        vpn_d        = vpn_q;
        idx_d        = idx_q;
        r0_ack_d     = 1'b0;
        r1_ack_d     = 1'b0;
        flush_done_d = 1'b0;
        phys_d       = phys_q;
        tag_d        = tag_q;
        fault_d      = fault_q;
        arb_update   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (flush_v) begin
                    state_d = StFlush;
                end else if (req_v != 2'b00) begin
                    arb_update = 1'b1;
                    idx_d      = gnt[1];
                    vpn_d      = vpn_sel;
                    if (satp_mode) begin
                        state_d = StIssue;
                    end else begin
                        r0_ack_d = ~gnt[1];
                        r1_ack_d = gnt[1];
                        phys_d   = {{(PPN_W - VPN_W){1'b0}}, vpn_sel};
                        tag_d    = {TAG_W{1'b1}};
                        fault_d  = 1'b0;
                    end
                end
            end
            StIssue: begin
                state_d = StLookup;
            end
            StLookup: begin
                if (tlb_done) begin
                    if (tlb_miss) begin
                        state_d = StWalk;
                    end else begin
                        state_d  = StIdle;
                        r0_ack_d = ~idx_q;
                        r1_ack_d = idx_q;
                        phys_d   = tlb_phys_r;
                        tag_d    = tlb_accesstag_r;
                        fault_d  = 1'b0;
                    end
                end
            end
            StWalk: begin
                if (ptw_done) begin
                    state_d  = StIdle;
                    r0_ack_d = ~idx_q;
                    r1_ack_d = idx_q;
                    if (ptw_fault) begin
                        phys_d  = '0;
                        tag_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        phys_d  = ptw_phys;
                        tag_d   = ptw_accesstag;
                        fault_d = 1'b0;
                    end
                end
            end
            StFlush: begin
                state_d      = StIdle;
                flush_done_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            vpn_q        <= '0;
            idx_q        <= 1'b0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            flush_done_q <= 1'b0;
            phys_q       <= '0;
            tag_q        <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            idx_q        <= idx_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            flush_done_q <= flush_done_d;
            phys_q       <= phys_d;
            tag_q        <= tag_d;
            fault_q      <= fault_d;
        end
    end

    assign r0_ack      = r0_ack_q;
    assign r1_ack      = r1_ack_q;
    assign flush_done  = flush_done_q;
    assign r_phys      = phys_q;
    assign r_accesstag = tag_q;
    assign r_pagefault = fault_q;

    // The fill is written in the same cycle the walk completes; no re-lookup follows.
    assign tlb_resolve     = (state_q == StIssue);
    assign tlb_invalidate  = (state_q == StFlush);
    assign tlb_write       = (state_q == StWalk) & ptw_done & ~ptw_fault;
    assign tlb_enable      = tlb_resolve | tlb_invalidate | tlb_write;
    assign tlb_vaddr       = vpn_q;
    assign tlb_vaddr_w     = vpn_q;
    assign tlb_phys_w      = ptw_phys;
    assign tlb_accesstag_w = ptw_accesstag;
    assign ptw_req         = (state_q == StWalk);
    assign ptw_vpn         = vpn_q;

endmodule

// File: tb/tb_armleocpu_tlb_ctrl.sv
// Bench for armleocpu_tlb_ctrl: behavioural TLB and page-table-walker models, ack scoreboard.
module tb_armleocpu_tlb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        satp_mode = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        r0_req = 1'b0;
    logic [19:0] r0_vpn = '0;
    logic        r0_ack;
    logic        r1_req = 1'b0;
    logic [19:0] r1_vpn = '0;
    logic        r1_ack;
    logic [21:0] r_phys;
    logic [7:0]  r_accesstag;
    logic        r_pagefault;
    logic        tlb_enable, tlb_resolve, tlb_invalidate, tlb_write;
    logic [19:0] tlb_vaddr, tlb_vaddr_w;
    logic [21:0] tlb_phys_w;
    logic [7:0]  tlb_accesstag_w;
    logic        tlb_done = 1'b0;
    logic        tlb_miss = 1'b0;
    logic [21:0] tlb_phys_r = '0;
    logic [7:0]  tlb_accesstag_r = '0;
    logic        ptw_req;
    logic [19:0] ptw_vpn;
    logic        ptw_done = 1'b0;
    logic        ptw_fault = 1'b0;
    logic [21:0] ptw_phys = '0;
    logic [7:0]  ptw_accesstag = '0;

    armleocpu_tlb_ctrl #(
        .ARB_RESET_PRIO (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .satp_mode       (satp_mode),
        .flush_req       (flush_req),
        .flush_done      (flush_done),
        .r0_req          (r0_req),
        .r0_vpn          (r0_vpn),
        .r0_ack          (r0_ack),
        .r1_req          (r1_req),
        .r1_vpn          (r1_vpn),
        .r1_ack          (r1_ack),
        .r_phys          (r_phys),
        .r_accesstag     (r_accesstag),
        .r_pagefault     (r_pagefault),
        .tlb_enable      (tlb_enable),
        .tlb_resolve     (tlb_resolve),
        .tlb_invalidate  (tlb_invalidate),
        .tlb_write       (tlb_write),
        .tlb_vaddr       (tlb_vaddr),
        .tlb_vaddr_w     (tlb_vaddr_w),
        .tlb_phys_w      (tlb_phys_w),
        .tlb_accesstag_w (tlb_accesstag_w),
        .tlb_done        (tlb_done),
        .tlb_miss        (tlb_miss),
        .tlb_phys_r      (tlb_phys_r),
        .tlb_accesstag_r (tlb_accesstag_r),
        .ptw_req         (ptw_req),
        .ptw_vpn         (ptw_vpn),
        .ptw_done        (ptw_done),
        .ptw_fault       (ptw_fault),
        .ptw_phys        (ptw_phys),
        .ptw_accesstag   (ptw_accesstag)
    );

    always #5 clk = ~clk;

    // TLB model: one-cycle resolve latency, small fully associative store.
    logic [19:0] m_vpn  [8];
    logic [21:0] m_phys [8];
    logic [7:0]  m_tag  [8];
    logic        m_val  [8] = '{default: 1'b0};
    int          m_fill = 0;

    always @(posedge clk) begin
        tlb_done <= 1'b0;
        if (tlb_resolve) begin
            tlb_done        <= 1'b1;
            tlb_miss        <= 1'b1;
            tlb_phys_r      <= '0;
            tlb_accesstag_r <= '0;
            for (int i = 0; i < 8; i++) begin
                if (m_val[i] && m_vpn[i] == tlb_vaddr) begin
                    tlb_miss        <= 1'b0;
                    tlb_phys_r      <= m_phys[i];
                    tlb_accesstag_r <= m_tag[i];
                end
            end
        end
        if (tlb_write) begin
            m_val[m_fill]  <= 1'b1;
            m_vpn[m_fill]  <= tlb_vaddr_w;
            m_phys[m_fill] <= tlb_phys_w;
            m_tag[m_fill]  <= tlb_accesstag_w;
            m_fill         <= (m_fill + 1) % 8;
        end
        if (tlb_invalidate) begin
            for (int i = 0; i < 8; i++) m_val[i] <= 1'b0;
        end
    end

    // Walker model: answers ptw_delay+1 cycles after ptw_req is first seen.
    int ptw_delay = 2;
    int p_cnt = 0;
    always @(posedge clk) begin
        if (ptw_req && !ptw_done) begin
            if (p_cnt == ptw_delay) begin
                ptw_done <= 1'b1;
                p_cnt    <= 0;
            end else begin
                p_cnt <= p_cnt + 1;
            end
        end else begin
            ptw_done <= 1'b0;
            if (!ptw_req) p_cnt <= 0;
        end
    end

    // Event monitor: counts strobes for the main process to inspect.
    int          mon_cyc = 0, resolve_cnt = 0, write_cnt = 0, inval_cnt = 0;
    int          ptw_cyc = 0, fdone_cnt = 0, write_cyc = 0, inval_cyc = 0;
    logic [19:0] w_vpn = '0, last_ptw_vpn = '0;
    logic [21:0] w_phys = '0;
    logic [7:0]  w_tag = '0;

    always @(negedge clk) begin
        mon_cyc <= mon_cyc + 1;
        if (tlb_resolve) resolve_cnt <= resolve_cnt + 1;
        if (tlb_write) begin
            write_cnt <= write_cnt + 1;
            write_cyc <= mon_cyc;
            w_vpn     <= tlb_vaddr_w;
            w_phys    <= tlb_phys_w;
            w_tag     <= tlb_accesstag_w;
        end
        if (tlb_invalidate) begin
            inval_cnt <= inval_cnt + 1;
            inval_cyc <= mon_cyc;
        end
        if (ptw_req) begin
            ptw_cyc      <= ptw_cyc + 1;
            last_ptw_vpn <= ptw_vpn;
        end
        if (flush_done) fdone_cnt <= fdone_cnt + 1;
    end

    typedef struct {
        int          idx;
        logic [21:0] phys;
        logic [7:0]  tag;
        logic        fault;
        int          issue;
        int          lat;
    } exp_t;

    typedef struct {
        int          idx;
        logic [19:0] vpn;
        logic        satp;
        logic        pf;
        logic [21:0] pphys;
        logic [7:0]  ptag;
        logic [21:0] ephys;
        logic [7:0]  etag;
        logic        efault;
        int          elat;
        logic        walk;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs [8];
    int   n_cmp = 0, n_bad = 0, tcyc = 0;
    logic drop0 = 1'b0, drop1 = 1'b0, dropf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_ack(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected ack: got ack on r%0d, expected none", idx);
        end else begin
            e = exp_q.pop_front();
            chk("ack requester", idx, e.idx);
            chk("ack r_phys", r_phys, e.phys);
            chk("ack r_accesstag", r_accesstag, e.tag);
            chk("ack r_pagefault", r_pagefault, e.fault);
            if (e.lat >= 0) chk("ack latency", tcyc - e.issue, e.lat);
        end
    endtask

    // Requesters drop req the cycle after they see their ack, like registered logic would.
    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
        if (drop0) begin r0_req = 1'b0; drop0 = 1'b0; end
        if (drop1) begin r1_req = 1'b0; drop1 = 1'b0; end
        if (dropf) begin flush_req = 1'b0; dropf = 1'b0; end
        if (r0_ack) begin check_ack(0); drop0 = 1'b1; end
        if (r1_ack) begin check_ack(1); drop1 = 1'b1; end
        if (flush_done) dropf = 1'b1;
    endtask

    task automatic raise(input int idx, input logic [19:0] vpn, input logic satp,
                         input logic [21:0] ephys, input logic [7:0] etag, input logic efault,
                         input int elat);
        exp_t e;
        satp_mode = satp;
        if (idx == 0) begin r0_vpn = vpn; r0_req = 1'b1; end
        else begin r1_vpn = vpn; r1_req = 1'b1; end
        e = '{idx: idx, phys: ephys, tag: etag, fault: efault, issue: tcyc, lat: elat};
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string what);
        int k = 0;
        while ((exp_q.size() != 0 || r0_req || r1_req || flush_req) && k < 80) begin
            tick();
            k++;
        end
        if (k >= 80) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout with %0d acks outstanding", what, exp_q.size());
            exp_q.delete();
            r0_req = 1'b0;
            r1_req = 1'b0;
            flush_req = 1'b0;
        end
        tick();
    endtask

    task automatic wait_ptw(input string what);
        int k = 0;
        while (!ptw_req && k < 40) begin
            tick();
            k++;
        end
        if (!ptw_req) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: ptw_req got 0, expected 1 within 40 cycles", what);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_req = 1'b0;
        r1_req = 1'b0;
        flush_req = 1'b0;
        drop0 = 1'b0;
        drop1 = 1'b0;
        dropf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int w0, p0, rs0, i0, f0;
        vecs[0] = '{0, 20'h12345, 1'b0, 1'b0, 22'h0, 8'h00, 22'h012345, 8'hFF, 1'b0, 1, 1'b0};
        vecs[1] = '{1, 20'h20000, 1'b1, 1'b0, 22'h10000, 8'hB1, 22'h10000, 8'hB1, 1'b0, 7, 1'b1};
        vecs[2] = '{1, 20'h20000, 1'b1, 1'b0, 22'h0, 8'h00, 22'h10000, 8'hB1, 1'b0, 3, 1'b0};
        vecs[3] = '{0, 20'h0ABCD, 1'b1, 1'b1, 22'h3AAAA, 8'h11, 22'h0, 8'h00, 1'b1, 7, 1'b1};
        vecs[4] = '{0, 20'h0ABCD, 1'b1, 1'b0, 22'h3FFFFF, 8'h5A, 22'h3FFFFF, 8'h5A, 1'b0, 7, 1'b1};
        vecs[5] = '{1, 20'h0ABCD, 1'b1, 1'b0, 22'h0, 8'h00, 22'h3FFFFF, 8'h5A, 1'b0, 3, 1'b0};
        vecs[6] = '{1, 20'hFFFFF, 1'b0, 1'b0, 22'h0, 8'h00, 22'h0FFFFF, 8'hFF, 1'b0, 1, 1'b0};
        vecs[7] = '{0, 20'h20000, 1'b1, 1'b0, 22'h0, 8'h00, 22'h10000, 8'hB1, 1'b0, 3, 1'b0};

        tick();
        tick();
        chk("reset strobes", {r0_ack, r1_ack, flush_done, tlb_resolve, tlb_write, tlb_invalidate,
                              ptw_req, tlb_enable}, 8'h00);
        chk("reset r_phys", r_phys, 22'h0);
        chk("reset r_accesstag", r_accesstag, 8'h00);
        chk("reset r_pagefault", r_pagefault, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ptw_fault     = vecs[i].pf;
            ptw_phys      = vecs[i].pphys;
            ptw_accesstag = vecs[i].ptag;
            w0  = write_cnt;
            p0  = ptw_cyc;
            rs0 = resolve_cnt;
            raise(vecs[i].idx, vecs[i].vpn, vecs[i].satp, vecs[i].ephys, vecs[i].etag,
                  vecs[i].efault, vecs[i].elat);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tlb_write count", i), write_cnt - w0,
                (vecs[i].walk && !vecs[i].pf) ? 1 : 0);
            chk($sformatf("vec%0d walk requested", i), (ptw_cyc != p0) ? 1 : 0,
                vecs[i].walk ? 1 : 0);
            chk($sformatf("vec%0d resolve count", i), resolve_cnt - rs0, vecs[i].satp ? 1 : 0);
            if (vecs[i].walk) chk($sformatf("vec%0d ptw_vpn", i), last_ptw_vpn, vecs[i].vpn);
            if (vecs[i].walk && !vecs[i].pf) begin
                chk($sformatf("vec%0d fill vpn", i), w_vpn, vecs[i].vpn);
                chk($sformatf("vec%0d fill phys", i), w_phys, vecs[i].pphys);
                chk($sformatf("vec%0d fill tag", i), w_tag, vecs[i].ptag);
            end
        end
        tick();
        tick();
        chk("r_phys held after ack", r_phys, 22'h10000);

        // Arbitration from reset: r0 holds priority, then the pointer alternates.
        do_reset();
        raise(0, 20'h00111, 1'b0, 22'h000111, 8'hFF, 1'b0, 1);
        raise(1, 20'h00222, 1'b0, 22'h000222, 8'hFF, 1'b0, 2);
        wait_done("arb pair 1");
        raise(0, 20'h00333, 1'b0, 22'h000333, 8'hFF, 1'b0, 1);
        wait_done("arb single r0");
        raise(1, 20'h00444, 1'b0, 22'h000444, 8'hFF, 1'b0, 1);
        raise(0, 20'h00555, 1'b0, 22'h000555, 8'hFF, 1'b0, 2);
        wait_done("arb pair 2");

        // Flush raised together with both requests goes first.
        do_reset();
        f0 = fdone_cnt;
        raise(0, 20'h00777, 1'b0, 22'h000777, 8'hFF, 1'b0, 3);
        raise(1, 20'h00888, 1'b0, 22'h000888, 8'hFF, 1'b0, 4);
        flush_req = 1'b1;
        tick();
        chk("flush beats requests", tlb_invalidate, 1'b1);
        wait_done("flush priority");
        chk("flush_done pulse width", fdone_cnt - f0, 1);

        // Flush during a walk: the fill lands first, then the invalidate.
        satp_mode = 1'b1;
        ptw_delay = 4;
        ptw_fault = 1'b0;
        ptw_phys = 22'h22222;
        ptw_accesstag = 8'h77;
        w0 = write_cnt;
        i0 = inval_cnt;
        f0 = fdone_cnt;
        raise(1, 20'h30000, 1'b1, 22'h22222, 8'h77, 1'b0, -1);
        wait_ptw("flush in walk");
        flush_req = 1'b1;
        wait_done("flush in walk");
        chk("walk fill before flush", write_cnt - w0, 1);
        chk("invalidate cycles", inval_cnt - i0, 1);
        chk("invalidate after fill", (inval_cyc > write_cyc) ? 1 : 0, 1);
        chk("flush_done after walk", fdone_cnt - f0, 1);
        ptw_delay = 2;
        ptw_phys = 22'h10000;
        ptw_accesstag = 8'hB1;
        p0 = ptw_cyc;
        raise(0, 20'h20000, 1'b1, 22'h10000, 8'hB1, 1'b0, 7);
        wait_done("lookup after flush");
        chk("lookup after flush misses", (ptw_cyc != p0) ? 1 : 0, 1);

        // Reset in the middle of a walk drops it silently.
        ptw_delay = 1000;
        satp_mode = 1'b1;
        r0_vpn = 20'h40000;
        r0_req = 1'b1;
        wait_ptw("reset in walk");
        rst = 1'b1;
        tick();
        chk("ptw_req after rst", ptw_req, 1'b0);
        chk("no ack after rst", {r0_ack, r1_ack}, 2'b00);
        rst = 1'b0;
        r0_req = 1'b0;
        ptw_delay = 2;
        for (int i = 0; i < 5; i++) tick();
        raise(1, 20'h55555, 1'b0, 22'h055555, 8'hFF, 1'b0, 1);
        wait_done("after reset in walk");

        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
